// File: rtl/div_sched_pkg.sv
// Shared types and constants for the div_sched divider scheduler.
package div_sched_pkg;

   localparam int TMO_CYC_DEF = 64;
   localparam int DIV_DW_MAX  = 64;
   localparam int DIV_ID_MAX  = 3;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DROP,
      WAIT_RDY,
      RESP
   } div_sched_st_t;

   // Sized for the widest supported build; narrower builds cast on the way in and out.
   typedef struct packed {
      logic [DIV_DW_MAX-1:0] a;
      logic [DIV_DW_MAX-1:0] b;
      logic [DIV_ID_MAX-1:0] id;
   } div_req_t;

   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward, pointer moves past the winner on advance.
module rr_arbiter
   import div_sched_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  req_i,
   input  logic          advance_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW-1:0] r_ptr;
   logic          w_found;

   function automatic int rr_pos(input int p, input int i, input int n);
      int j;
      j = p + i;
      return (j >= n) ? j - n : j;
   endfunction

   always_comb begin
      // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
      grant_o = '0;
      idx_o   = '0;
      w_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && req_i[rr_pos(int'(r_ptr), i, N)]) begin
            w_found                           = 1'b1;
            idx_o                             = IW'(rr_pos(int'(r_ptr), i, N));
            grant_o[rr_pos(int'(r_ptr), i, N)] = 1'b1;
         end
      end
   end

   assign any_o = w_found;

   // NOTE: state is updated with <= so every flop samples the pre-edge values of its inputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr <= '0;
      end else if (advance_i) begin
         r_ptr <= IW'(wrap_inc(int'(idx_o), N));
      end
   end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider between N_REQ requesters.
// Optional feature: define DIV_ZERO_BYPASS_EN to answer B=0 requests without using the divider.
module div_sched
   import div_sched_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int DW      = 32,
   parameter  int TMO_CYC = TMO_CYC_DEF,
   localparam int IW      = $clog2(N_REQ)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [N_REQ-1:0]    req_valid_i,
   input  logic [N_REQ*DW-1:0] req_a_i,
   input  logic [N_REQ*DW-1:0] req_b_i,
   output logic [N_REQ-1:0]    req_ready_o,
   output logic                div_start_o,
   output logic [DW-1:0]       div_a_o,
   output logic [DW-1:0]       div_b_o,
   input  logic                div_ready_i,
   input  logic [DW-1:0]       div_quotient_i,
   input  logic [DW-1:0]       div_remainder_i,
   output logic                rsp_valid_o,
   output logic [IW-1:0]       rsp_id_o,
   output logic [DW-1:0]       rsp_quotient_o,
   output logic [DW-1:0]       rsp_remainder_o,
   output logic                rsp_err_o,
   output logic                busy_o
);

   localparam int CW = $clog2(TMO_CYC + 1);

   div_sched_st_t    r_state, w_next;
   div_req_t         r_req;
   logic [DW-1:0]    r_quot, r_rem;
   logic             r_err;
   logic [CW-1:0]    r_cnt;

   logic [N_REQ-1:0] w_grant;
   logic [IW-1:0]    w_idx;
   logic             w_any, w_accept, w_bypass, w_tmo;
   logic [DW-1:0]    w_a_sel, w_b_sel;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_valid_i),
      .advance_i (w_accept),
      .grant_o   (w_grant),
      .idx_o     (w_idx),
      .any_o     (w_any)
   );

   assign w_a_sel = req_a_i[w_idx*DW +: DW];
   assign w_b_sel = req_b_i[w_idx*DW +: DW];

   // Gating on div_ready_i also covers a divider still busy from an op aborted by reset.
   assign w_accept = (r_state == IDLE) && div_ready_i && w_any && !rst_i;
   assign w_tmo    = (r_cnt == CW'(TMO_CYC - 1));

`ifdef DIV_ZERO_BYPASS_EN
   assign w_bypass = (w_b_sel == '0);
`else
   assign w_bypass = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_accept) w_next = w_bypass ? RESP : ISSUE;
         ISSUE:     w_next = WAIT_DROP;
         WAIT_DROP: w_next = WAIT_RDY;
         WAIT_RDY:  if (div_ready_i || w_tmo) w_next = RESP;
         RESP:      w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      div_start_o = 1'b0;
      rsp_valid_o = 1'b0;
      rsp_err_o   = 1'b0;
      busy_o      = (r_state != IDLE);
      case (r_state)
         IDLE:    if (w_accept) req_ready_o = w_grant;
         ISSUE:   div_start_o = 1'b1;
         RESP: begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = r_err;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_req  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_err  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         if (w_accept) begin
            r_req <= '{a: DIV_DW_MAX'(w_a_sel), b: DIV_DW_MAX'(w_b_sel), id: DIV_ID_MAX'(w_idx)};
            if (w_bypass) begin
               r_quot <= '1;
               r_rem  <= w_a_sel;
               r_err  <= 1'b1;
            end
         end
         case (r_state)
            ISSUE:     r_cnt <= '0;
            WAIT_DROP: r_cnt <= r_cnt + 1'b1;
            WAIT_RDY: begin
               r_cnt <= r_cnt + 1'b1;
               // Ready is checked first so a simultaneous timeout still completes normally.
               if (div_ready_i) begin
                  r_quot <= div_quotient_i;
                  r_rem  <= div_remainder_i;
                  r_err  <= 1'b0;
               end else if (w_tmo) begin
                  r_quot <= '0;
                  r_rem  <= '0;
                  r_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_a_o         = DW'(r_req.a);
   assign div_b_o         = DW'(r_req.b);
   assign rsp_id_o        = IW'(r_req.id);
   assign rsp_quotient_o  = r_quot;
   assign rsp_remainder_o = r_rem;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural divider whose latency and hang are controllable.
module tb_div_sched;

   localparam int N_REQ   = 4;
   localparam int DW      = 32;
   localparam int TMO_CYC = 64;
   localparam int IW      = 2;

   logic                clk = 1'b0;
   logic                rst_i = 1'b1;
   logic [N_REQ-1:0]    req_valid = '0;
   logic [N_REQ*DW-1:0] req_a = '0;
   logic [N_REQ*DW-1:0] req_b = '0;
   logic [N_REQ-1:0]    req_ready_o;
   logic                div_start_o;
   logic [DW-1:0]       div_a_o, div_b_o;
   logic                div_ready_i;
   logic [DW-1:0]       div_quotient_i, div_remainder_i;
   logic                rsp_valid_o;
   logic [IW-1:0]       rsp_id_o;
   logic [DW-1:0]       rsp_quotient_o, rsp_remainder_o;
   logic                rsp_err_o;
   logic                busy_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int   div_lat = 5;
   logic hang    = 1'b0;
   int   div_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: ready drops the cycle after start and returns after div_lat cycles.
   always @(posedge clk) begin
      if (div_start_o)                div_cnt <= div_lat;
      else if (div_cnt != 0 && !hang) div_cnt <= div_cnt - 1;
   end
   assign div_ready_i     = (div_cnt == 0);
   assign div_quotient_i  = (div_b_o != '0) ? div_a_o / div_b_o : '1;
   assign div_remainder_i = (div_b_o != '0) ? div_a_o % div_b_o : div_a_o;

   div_sched #(.N_REQ(N_REQ), .DW(DW), .TMO_CYC(TMO_CYC)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .req_valid_i     (req_valid),
      .req_a_i         (req_a),
      .req_b_i         (req_b),
      .req_ready_o     (req_ready_o),
      .div_start_o     (div_start_o),
      .div_a_o         (div_a_o),
      .div_b_o         (div_b_o),
      .div_ready_i     (div_ready_i),
      .div_quotient_i  (div_quotient_i),
      .div_remainder_i (div_remainder_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_id_o        (rsp_id_o),
      .rsp_quotient_o  (rsp_quotient_o),
      .rsp_remainder_o (rsp_remainder_o),
      .rsp_err_o       (rsp_err_o),
      .busy_o          (busy_o)
   );

   task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_a[k*DW +: DW] = a;
      req_b[k*DW +: DW] = b;
      req_valid[k]      = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int budget, output int at, output logic ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (req_ready_o != '0) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_rsp(input int budget, output int at, output logic ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rsp_valid_o) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
      end
   endtask

   task automatic do_reset();
      step();
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i     = 1'b1;
      req_valid = '1;
      req_a     = {32'd9, 32'd8, 32'd7, 32'd6};
      req_b     = {32'd3, 32'd2, 32'd1, 32'd5};
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({req_ready_o, div_start_o, rsp_valid_o, busy_o, rsp_err_o} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 0",
                  {req_ready_o, div_start_o, rsp_valid_o, busy_o, rsp_err_o});
      end
      checks++;
      if ({div_a_o, div_b_o, rsp_quotient_o, rsp_remainder_o, rsp_id_o} !== '0) begin
         failures++;
         $display("FAIL reset_data: got a=%0h b=%0h q=%0h r=%0h id=%0d expected all 0",
                  div_a_o, div_b_o, rsp_quotient_o, rsp_remainder_o, rsp_id_o);
      end
      step();
      rst_i     = 1'b0;
      req_valid = '0;
   endtask

   task automatic test_single();
      int t, tr;
      logic ok;
      div_lat = 32;
      set_req(0, 32'd100, 32'd7);
      wait_grant(50, t, ok);
      checks++;
      if (!ok || req_ready_o !== 4'b0001) begin
         failures++;
         $display("FAIL single_grant: got ok=%0b ready=%b expected 0001", ok, req_ready_o);
      end
      step();
      req_valid = '0;
      @(negedge clk);
      checks++;
      if ({div_start_o, div_a_o, div_b_o} !== {1'b1, 32'd100, 32'd7}) begin
         failures++;
         $display("FAIL single_start: got start=%0b a=%0d b=%0d expected 1 100 7",
                  div_start_o, div_a_o, div_b_o);
      end
      wait_rsp(200, tr, ok);
      checks++;
      if (!ok || tr - t != 35) begin
         failures++;
         $display("FAIL single_latency: got ok=%0b lat=%0d expected 35", ok, tr - t);
      end
      checks++;
      if ({rsp_id_o, rsp_quotient_o, rsp_remainder_o, rsp_err_o} !== {2'd0, 32'd14, 32'd2, 1'b0}) begin
         failures++;
         $display("FAIL single_result: got id=%0d q=%0d r=%0d err=%0b expected 0 14 2 0",
                  rsp_id_o, rsp_quotient_o, rsp_remainder_o, rsp_err_o);
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid_o, busy_o} !== 2'b00) begin
         failures++;
         $display("FAIL single_pulse: got valid=%0b busy=%0b expected 0 0", rsp_valid_o, busy_o);
      end
   endtask

   task automatic test_round_robin();
      int exp_k [5] = '{0, 1, 2, 3, 0};
      int exp_q [4] = '{14, 27, 7, 333};
      int exp_r [4] = '{2, 7, 7, 1};
      int t, tr, prev;
      logic ok;
      do_reset();
      div_lat = 5;
      set_req(0, 32'd100, 32'd7);
      set_req(1, 32'd250, 32'd9);
      set_req(2, 32'd77, 32'd10);
      set_req(3, 32'd1000, 32'd3);
      prev = 0;
      for (int g = 0; g < 5; g++) begin
         wait_grant(50, t, ok);
         checks++;
         if (!ok || req_ready_o !== N_REQ'(1 << exp_k[g])) begin
            failures++;
            $display("FAIL rr_grant%0d: got ok=%0b ready=%b expected k=%0d",
                     g, ok, req_ready_o, exp_k[g]);
         end
         if (g > 0) begin
            checks++;
            if (t - prev != div_lat + 4) begin
               failures++;
               $display("FAIL rr_throughput%0d: got %0d expected %0d", g, t - prev, div_lat + 4);
            end
         end
         prev = t;
         wait_rsp(100, tr, ok);
         checks++;
         if (!ok || rsp_id_o !== IW'(exp_k[g]) || rsp_quotient_o !== DW'(exp_q[exp_k[g]]) ||
             rsp_remainder_o !== DW'(exp_r[exp_k[g]]) || rsp_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rr_rsp%0d: got ok=%0b id=%0d q=%0d r=%0d err=%0b expected %0d %0d %0d 0",
                     g, ok, rsp_id_o, rsp_quotient_o, rsp_remainder_o, rsp_err_o,
                     exp_k[g], exp_q[exp_k[g]], exp_r[exp_k[g]]);
         end
      end
      step();
      req_valid = '0;
   endtask

   task automatic test_ready_during_drop();
      int t, tr;
      logic ok;
      div_lat = 0;
      set_req(1, 32'd250, 32'd9);
      wait_grant(50, t, ok);
      step();
      req_valid = '0;
      wait_rsp(50, tr, ok);
      checks++;
      if (!ok || tr - t != 4 || rsp_quotient_o !== 32'd27 || rsp_remainder_o !== 32'd7) begin
         failures++;
         $display("FAIL drop_ignored: got ok=%0b lat=%0d q=%0d r=%0d expected 4 27 7",
                  ok, tr - t, rsp_quotient_o, rsp_remainder_o);
      end
   endtask

   task automatic test_tmo_vs_ready();
      int t, tr;
      logic ok;
      div_lat = 63;
      set_req(2, 32'd77, 32'd10);
      wait_grant(50, t, ok);
      step();
      req_valid = '0;
      wait_rsp(200, tr, ok);
      checks++;
      if (!ok || tr - t != 66 || rsp_err_o !== 1'b0 || rsp_quotient_o !== 32'd7 ||
          rsp_remainder_o !== 32'd7 || rsp_id_o !== 2'd2) begin
         failures++;
         $display("FAIL ready_wins: got ok=%0b lat=%0d err=%0b q=%0d r=%0d id=%0d expected 66 0 7 7 2",
                  ok, tr - t, rsp_err_o, rsp_quotient_o, rsp_remainder_o, rsp_id_o);
      end
   endtask

   task automatic test_timeout();
      int t, tr, bad;
      logic ok;
      div_lat = 5;
      hang    = 1'b1;
      set_req(3, 32'd1000, 32'd3);
      wait_grant(50, t, ok);
      step();
      req_valid = '0;
      wait_rsp(200, tr, ok);
      checks++;
      if (!ok || tr - t != 66) begin
         failures++;
         $display("FAIL tmo_latency: got ok=%0b lat=%0d expected 66", ok, tr - t);
      end
      checks++;
      if ({rsp_err_o, rsp_quotient_o, rsp_remainder_o, rsp_id_o} !== {1'b1, 32'd0, 32'd0, 2'd3}) begin
         failures++;
         $display("FAIL tmo_result: got err=%0b q=%0d r=%0d id=%0d expected 1 0 0 3",
                  rsp_err_o, rsp_quotient_o, rsp_remainder_o, rsp_id_o);
      end
      step();
      set_req(0, 32'd100, 32'd7);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (req_ready_o != '0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL tmo_no_grant: got %0d grants while divider busy expected 0", bad);
      end
      step();
      hang = 1'b0;
      wait_grant(30, t, ok);
      checks++;
      if (!ok || req_ready_o !== 4'b0001 || div_ready_i !== 1'b1) begin
         failures++;
         $display("FAIL tmo_regrant: got ok=%0b ready=%b div_ready=%0b expected 0001 with ready",
                  ok, req_ready_o, div_ready_i);
      end
      step();
      req_valid = '0;
      wait_rsp(100, tr, ok);
      checks++;
      if (!ok || rsp_quotient_o !== 32'd14 || rsp_err_o !== 1'b0) begin
         failures++;
         $display("FAIL tmo_recover: got ok=%0b q=%0d err=%0b expected 14 0",
                  ok, rsp_quotient_o, rsp_err_o);
      end
   endtask

   task automatic test_div_zero();
      int t, tr;
      logic ok;
      div_lat = 5;
      set_req(1, 32'd55, 32'd0);
      wait_grant(50, t, ok);
      checks++;
      if (!ok || req_ready_o !== 4'b0010) begin
         failures++;
         $display("FAIL dz_grant: got ok=%0b ready=%b expected 0010", ok, req_ready_o);
      end
      step();
      req_valid = '0;
      @(negedge clk);
`ifdef DIV_ZERO_BYPASS_EN
      checks++;
      if ({div_start_o, rsp_valid_o} !== 2'b01) begin
         failures++;
         $display("FAIL dz_bypass: got start=%0b valid=%0b expected 0 1", div_start_o, rsp_valid_o);
      end
      checks++;
      if ({rsp_quotient_o, rsp_remainder_o, rsp_err_o, rsp_id_o} !== {32'hFFFF_FFFF, 32'd55, 1'b1, 2'd1}) begin
         failures++;
         $display("FAIL dz_result: got q=%0h r=%0d err=%0b id=%0d expected ffffffff 55 1 1",
                  rsp_quotient_o, rsp_remainder_o, rsp_err_o, rsp_id_o);
      end
`else
      checks++;
      if ({div_start_o, div_b_o} !== {1'b1, 32'd0}) begin
         failures++;
         $display("FAIL dz_issue: got start=%0b b=%0d expected 1 0", div_start_o, div_b_o);
      end
      wait_rsp(100, tr, ok);
      checks++;
      if (!ok || tr - t != div_lat + 3 || rsp_err_o !== 1'b0 || rsp_id_o !== 2'd1 ||
          rsp_remainder_o !== 32'd55) begin
         failures++;
         $display("FAIL dz_divider: got ok=%0b lat=%0d err=%0b id=%0d r=%0d expected 8 0 1 55",
                  ok, tr - t, rsp_err_o, rsp_id_o, rsp_remainder_o);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int t, tr, bad_rsp, bad_grant;
      logic ok;
      div_lat = 32;
      set_req(1, 32'd100, 32'd7);
      wait_grant(50, t, ok);
      step();
      req_valid = '0;
      repeat (10) @(negedge clk);
      checks++;
      if ({busy_o, div_ready_i} !== 2'b10) begin
         failures++;
         $display("FAIL mid_precond: got busy=%0b div_ready=%0b expected 1 0", busy_o, div_ready_i);
      end
      step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      set_req(0, 32'd100, 32'd7);
      set_req(2, 32'd77, 32'd10);
      @(negedge clk);
      checks++;
      if ({req_ready_o, div_start_o, rsp_valid_o, busy_o, rsp_err_o, div_a_o, rsp_quotient_o} !== '0) begin
         failures++;
         $display("FAIL mid_outputs: got ready=%b start=%0b valid=%0b busy=%0b a=%0d q=%0d expected 0",
                  req_ready_o, div_start_o, rsp_valid_o, busy_o, div_a_o, rsp_quotient_o);
      end
      bad_rsp   = 0;
      bad_grant = 0;
      ok        = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid_o) bad_rsp++;
         if (req_ready_o != '0) begin
            if (!div_ready_i) bad_grant++;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (bad_rsp != 0) begin
         failures++;
         $display("FAIL mid_no_rsp: got %0d responses after reset expected 0", bad_rsp);
      end
      checks++;
      if (!ok || bad_grant != 0 || req_ready_o !== 4'b0001) begin
         failures++;
         $display("FAIL mid_regrant: got ok=%0b early=%0d ready=%b expected 0001 once divider ready",
                  ok, bad_grant, req_ready_o);
      end
      step();
      req_valid[0] = 1'b0;
      wait_rsp(100, tr, ok);
      checks++;
      if (!ok || rsp_id_o !== 2'd0 || rsp_quotient_o !== 32'd14) begin
         failures++;
         $display("FAIL mid_rsp0: got ok=%0b id=%0d q=%0d expected 0 14", ok, rsp_id_o, rsp_quotient_o);
      end
      wait_grant(50, t, ok);
      checks++;
      if (!ok || req_ready_o !== 4'b0100) begin
         failures++;
         $display("FAIL mid_grant2: got ok=%0b ready=%b expected 0100", ok, req_ready_o);
      end
      step();
      req_valid = '0;
      wait_rsp(100, tr, ok);
      checks++;
      if (!ok || rsp_id_o !== 2'd2 || rsp_quotient_o !== 32'd7 || rsp_remainder_o !== 32'd7) begin
         failures++;
         $display("FAIL mid_rsp2: got ok=%0b id=%0d q=%0d r=%0d expected 2 7 7",
                  ok, rsp_id_o, rsp_quotient_o, rsp_remainder_o);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ready_during_drop();
      test_tmo_vs_ready();
      test_timeout();
      test_div_zero();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler sharing one iterative unsigned divider (start/ready interface, quotient/remainder outputs) between `N_REQ` requesters in the tProc datapath. It accepts one operand pair at a time, pulses the divider start, waits for completion under a watchdog, and returns the result tagged with the requester index. Optional divide-by-zero bypass answers without occupying the divider.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `DW`, 32: operand/result width.
- `TMO_CYC`, 64: watchdog limit in cycles while waiting for the divider.

- `clk_i` in 1: single clock; all logic is on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in N_REQ: per-requester request; held until accepted.
- `req_a_i` in N_REQ*DW: dividends, requester k at `[k*DW +: DW]`.
- `req_b_i` in N_REQ*DW: divisors, same packing.
- `req_ready_o` out N_REQ: one-hot, one-cycle accept pulse.
- `div_start_o` out 1: one-cycle start pulse to the divider.
- `div_a_o`, `div_b_o` out DW: latched operands, stable from ISSUE until RESP.
- `div_ready_i` in 1: divider idle.
- `div_quotient_i`, `div_remainder_i` in DW: divider results.
- `rsp_valid_o` out 1: one-cycle result pulse. No backpressure.
- `rsp_id_o` out $clog2(N_REQ): requester index.
- `rsp_quotient_o`, `rsp_remainder_o` out DW: results.
- `rsp_err_o` out 1: 1 on timeout or divide-by-zero.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: if `div_ready_i`=1 and any `req_valid_i` is set, grant the round-robin winner. Pulse `req_ready_o[k]`, latch A, B and id. Go to ISSUE.
  - ISSUE: `div_start_o`=1. Go to WAIT_DROP.
  - WAIT_DROP: one cycle. `div_ready_i` is ignored because the divider deasserts ready only after the start edge.
  - WAIT_RDY: on `div_ready_i`=1, capture quotient and remainder and go to RESP.
  - RESP: `rsp_valid_o`=1. Go to IDLE.
- Round robin:
  - Pointer resets to 0.
  - Search order is pointer, pointer+1, … mod N_REQ.
  - After granting k, pointer becomes (k+1) mod N_REQ.
- Watchdog:
  - Counter clears in ISSUE and increments in WAIT_DROP and WAIT_RDY.
  - When the count reaches TMO_CYC without ready, go to RESP with `rsp_err_o`=1 and quotient = remainder = 0.
  - The next grant still waits for `div_ready_i`.
- Requests withdrawn before acceptance are legal and are never granted.
- Arithmetic is unsigned. Results pass through unmodified.

## Timing
- Reset values: every output 0, state IDLE, pointer 0, counter 0.
- Reset mid-operation aborts with no response. The divider is not reset by this block; IDLE gating on `div_ready_i` protects against a still-busy divider.
- Latency with divider busy for L cycles after start (ready low from the start edge +1):
  - Accept at cycle t.
  - Start at t+1.
  - Ready sampled from t+3.
  - `rsp_valid_o` at t+3+L−1+1, i.e. one cycle after ready is seen high.
- Earliest next accept is the cycle after RESP. Back-to-back throughput is one op per L+4 cycles.
- Ready held high during WAIT_DROP does not complete early.
- A timeout and ready arriving in the same cycle resolve as a normal completion (ready wins).

## Configuration
- `DIV_ZERO_BYPASS_EN` defined: in IDLE, a granted request with B=0 goes directly to RESP without `div_start_o`.
  - Response: quotient = all ones, remainder = A, `rsp_err_o`=1, `rsp_valid_o` at t+1.
  - Pointer advances as usual.
- Undefined: B=0 is issued to the divider like any other operand.

## Structure
- Shared package `div_sched_pkg`:
  - state enum `div_sched_st_t` (IDLE, ISSUE, WAIT_DROP, WAIT_RDY, RESP)
  - `div_req_t` struct {a, b, id}
  - default `TMO_CYC` constant
- Sub-module `rr_arbiter`: N-bit request in, one-hot grant and index out, pointer update on an `advance` input.

## Test plan
- Single request, A=100, B=7, divider model L=32: accept at t, start at t+1, then `rsp_valid_o` with id 0, q=14, r=2 and `rsp_err_o`=0, at the cycle after ready returns.
- All four requesters valid continuously with distinct operands: grants in order 0,1,2,3,0, with each response id matching its grant.
- Divider model never reasserts ready, TMO_CYC=64: `rsp_err_o`=1, q=r=0, and no new grant until ready is driven high.
- A=55, B=0 with `DIV_ZERO_BYPASS_EN`: no `div_start_o`, response at t+1 with q=0xFFFFFFFF, r=55, err=1. Without the macro, `div_start_o` pulses at t+1.
- `rst_i` pulsed in WAIT_RDY: no response, outputs 0 next cycle, pointer 0. A subsequent request from requester 2 is granted only once `div_ready_i`=1.
